// File: rtl/cla_seq_pkg.sv
// Shared types and sizing helpers for the nibble-serial CLA adder.
// Optional overflow flag is enabled with CLA_SEQ_OVF_EN.
package cla_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int NIB = 4;

    // Nibble index width; never narrower than one bit.
    function automatic int idx_w(input int width);
        int n;
        n = width / NIB;
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cla_seq_adder_slice.sv
// 4-bit carry-lookahead slice, purely combinational.
// Exposes c3 so the controller can derive signed overflow.
module cla4_slice (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] s,
    output logic       c3,
    output logic       cout
);

    logic [3:0] p;
    logic [3:0] g;
    logic [3:0] c;

    assign p = a ^ b;
    assign g = a & b;

    assign c[0] = cin;
    assign c[1] = g[0] | (p[0] & cin);
    assign c[2] = g[1] | (p[1] & g[0])
                | (p[1] & p[0] & cin);
    assign c[3] = g[2] | (p[2] & g[1])
                | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & cin);
    assign cout = g[3] | (p[3] & g[2])
                | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & cin);

    assign s  = p ^ c;
    assign c3 = c[3];

endmodule

// File: rtl/cla_seq_adder.sv
// WIDTH-bit adder that time-shares one CLA slice, one nibble per cycle.
// Define CLA_SEQ_OVF_EN to register signed overflow into ovf.
module cla_seq_adder
    import cla_seq_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             busy
);

    localparam int NN = WIDTH / NIB;
    localparam int IW = idx_w(WIDTH);
    localparam logic [IW-1:0] LAST = IW'(NN - 1);

    if ((WIDTH % NIB) != 0 || WIDTH < NIB) begin : g_bad_width
        $error("cla_seq_adder: WIDTH must be a multiple of 4, >= 4");
    end

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] sum_q;
    logic             carry_q;
    logic             cout_q;
    logic [IW-1:0]    idx_q;

    logic [NIB-1:0]   a_nib;
    logic [NIB-1:0]   b_nib;
    logic [NIB-1:0]   s_nib;
    logic             c3;
    logic             c_nib;
    logic             accept;
    logic             step;
    logic             last;

    assign a_nib  = NIB'(a_q >> (NIB * idx_q));
    assign b_nib  = NIB'(b_q >> (NIB * idx_q));
    assign accept = in_valid && (state_q == IDLE);
    assign step   = (state_q == RUN);
    assign last   = (idx_q == LAST);

    cla4_slice u_slice (
        .a    (a_nib),
        .b    (b_nib),
        .cin  (carry_q),
        .s    (s_nib),
        .c3   (c3),
        .cout (c_nib)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (in_valid)  state_d = RUN;
            RUN:     if (last)      state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        unique case (state_q)
            IDLE: in_ready = 1'b1;
            RUN:  busy = 1'b1;
            DONE: begin
                out_valid = 1'b1;
                busy      = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            idx_q   <= '0;
        end else begin
            unique case (1'b1)
                accept: begin
                    a_q     <= a;
                    b_q     <= b;
                    sum_q   <= '0;
                    carry_q <= cin;
                    cout_q  <= 1'b0;
                    idx_q   <= '0;
                end
                step: begin
                    sum_q[NIB*idx_q +: NIB] <= s_nib;
                    carry_q <= c_nib;
                    if (last) cout_q <= c_nib;
                    else      idx_q  <= idx_q + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign sum  = sum_q;
    assign cout = cout_q;

`ifdef CLA_SEQ_OVF_EN
    logic ovf_q;

    // Carry into the MSB is the slice's c3 on the final nibble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)              ovf_q <= 1'b0;
        else if (accept)         ovf_q <= 1'b0;
        else if (step && last)   ovf_q <= c3 ^ c_nib;
    end

    assign ovf = ovf_q;
`else
    logic unused_c3;

    assign unused_c3 = c3;
    assign ovf       = 1'b0;
`endif

endmodule

// File: tb/tb_cla_seq_adder.sv
// Directed and randomized checks of cla_seq_adder at WIDTH=16 and 4.
// Expected ovf follows CLA_SEQ_OVF_EN.
module tb_cla_seq_adder;

    localparam bit OVF_ON =
`ifdef CLA_SEQ_OVF_EN
        1'b1;
`else
        1'b0;
`endif

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n16, iv16, ir16, ov16, or16;
    logic        cin16, co16, of16, bz16;
    logic [15:0] a16, b16, s16;

    logic        rst_n4, iv4, ir4, ov4, or4;
    logic        cin4, co4, of4, bz4;
    logic [3:0]  a4, b4, s4;

    int n_vec = 0;
    int n_err = 0;

    cla_seq_adder #(.WIDTH(16)) u16 (
        .clk(clk), .rst_n(rst_n16),
        .in_valid(iv16), .in_ready(ir16),
        .a(a16), .b(b16), .cin(cin16),
        .out_valid(ov16), .out_ready(or16),
        .sum(s16), .cout(co16), .ovf(of16),
        .busy(bz16)
    );

    cla_seq_adder #(.WIDTH(4)) u4 (
        .clk(clk), .rst_n(rst_n4),
        .in_valid(iv4), .in_ready(ir4),
        .a(a4), .b(b4), .cin(cin4),
        .out_valid(ov4), .out_ready(or4),
        .sum(s4), .cout(co4), .ovf(of4),
        .busy(bz4)
    );

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h",
                     tag, got, exp);
        end
    endtask

    task automatic t16(input string tag,
                       input logic [15:0] ta, tb_,
                       input logic tc,
                       input logic [15:0] es,
                       input logic ec, eo,
                       input int hold, input bit junk);
        int lat;
        iv16 = 1'b1; a16 = ta; b16 = tb_; cin16 = tc;
        chk({tag, ".rdy"}, 32'(ir16), 1);
        @(posedge clk);
        @(negedge clk);
        iv16 = 1'b0;
        chk({tag, ".busy"}, 32'(bz16), 1);
        chk({tag, ".nrdy"}, 32'(ir16), 0);
        lat = 0;
        while (!ov16 && lat < 20) begin
            if (junk) begin
                iv16 = ~iv16;
                a16  = 16'hdead;
            end
            @(negedge clk);
            lat++;
        end
        iv16 = 1'b0;
        chk({tag, ".lat"}, 32'(lat), 4);
        chk({tag, ".sum"}, 32'(s16), 32'(es));
        chk({tag, ".cout"}, 32'(co16), 32'(ec));
        chk({tag, ".ovf"}, 32'(of16), 32'(eo));
        for (int i = 0; i < hold; i++) begin
            iv16 = junk;
            @(negedge clk);
            chk({tag, ".hv"}, 32'(ov16), 1);
            chk({tag, ".hs"}, 32'(s16), 32'(es));
            chk({tag, ".hc"}, 32'(co16), 32'(ec));
            chk({tag, ".hr"}, 32'(ir16), 0);
        end
        iv16 = 1'b0;
        or16 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        or16 = 1'b0;
        chk({tag, ".ovl"}, 32'(ov16), 0);
        chk({tag, ".idle"}, 32'(ir16), 1);
        if (junk) begin
            repeat (3) @(negedge clk);
            chk({tag, ".no2"}, 32'(ov16 | bz16), 0);
        end
    endtask

    task automatic t4(input string tag,
                      input logic [3:0] ta, tb_,
                      input logic tc,
                      input logic [3:0] es,
                      input logic ec, eo);
        int lat;
        iv4 = 1'b1; a4 = ta; b4 = tb_; cin4 = tc;
        chk({tag, ".rdy"}, 32'(ir4), 1);
        @(posedge clk);
        @(negedge clk);
        iv4 = 1'b0;
        lat = 0;
        while (!ov4 && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, ".lat"}, 32'(lat), 1);
        chk({tag, ".sum"}, 32'(s4), 32'(es));
        chk({tag, ".cout"}, 32'(co4), 32'(ec));
        chk({tag, ".ovf"}, 32'(of4), 32'(eo));
        or4 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        or4 = 1'b0;
        chk({tag, ".idle"}, 32'(ir4 & ~ov4), 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit hit");
        $fatal(1);
    end

    initial begin
        logic [3:0] ra, rb, rs;
        logic       rc, rco, reo;
        logic [4:0] full;

        rst_n16 = 1'b0; rst_n4 = 1'b0;
        iv16 = 1'b0; or16 = 1'b0; cin16 = 1'b0;
        a16 = '0; b16 = '0;
        iv4 = 1'b0; or4 = 1'b0; cin4 = 1'b0;
        a4 = '0; b4 = '0;
        repeat (2) @(negedge clk);
        chk("rst.rdy", 32'(ir16), 1);
        chk("rst.ov", 32'(ov16), 0);
        chk("rst.busy", 32'(bz16), 0);
        chk("rst.sum", 32'(s16), 0);
        chk("rst.cout", 32'(co16), 0);
        chk("rst.ovf", 32'(of16), 0);
        rst_n16 = 1'b1; rst_n4 = 1'b1;
        @(negedge clk);

        t16("ff+1", 16'h00ff, 16'h0001, 1'b0,
            16'h0100, 1'b0, 1'b0, 0, 1'b0);
        t16("ffff+1", 16'hffff, 16'h0001, 1'b0,
            16'h0000, 1'b1, 1'b0, 0, 1'b0);
        t16("ffff+cin", 16'hffff, 16'h0000, 1'b1,
            16'h0000, 1'b1, 1'b0, 0, 1'b0);
        t16("7fff+1", 16'h7fff, 16'h0001, 1'b0,
            16'h8000, 1'b0, OVF_ON, 0, 1'b0);
        t16("8000x2", 16'h8000, 16'h8000, 1'b0,
            16'h0000, 1'b1, OVF_ON, 0, 1'b0);
        t16("bp", 16'h1234, 16'h1111, 1'b0,
            16'h2345, 1'b0, 1'b0, 10, 1'b1);

        iv16 = 1'b1; a16 = 16'h1234; b16 = 16'h1111;
        cin16 = 1'b0;
        @(posedge clk);
        @(negedge clk);
        iv16 = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("mid.busy", 32'(bz16), 1);
        rst_n16 = 1'b0;
        #1;
        chk("mid.rdy", 32'(ir16), 1);
        chk("mid.ov", 32'(ov16), 0);
        chk("mid.busy0", 32'(bz16), 0);
        chk("mid.sum", 32'(s16), 0);
        chk("mid.cout", 32'(co16 | of16), 0);
        @(negedge clk);
        rst_n16 = 1'b1;
        @(negedge clk);
        t16("post", 16'h1234, 16'h4321, 1'b0,
            16'h5555, 1'b0, 1'b0, 0, 1'b0);

        t4("w4.f+1", 4'hf, 4'h1, 1'b0, 4'h0, 1'b1, 1'b0);
        for (int i = 0; i < 200; i++) begin
            ra   = 4'($urandom);
            rb   = 4'($urandom);
            rc   = 1'($urandom);
            full = {1'b0, ra} + {1'b0, rb} + {4'b0, rc};
            rs   = full[3:0];
            rco  = full[4];
            reo  = OVF_ON && (ra[3] == rb[3])
                          && (rs[3] != ra[3]);
            t4("w4.rnd", ra, rb, rc, rs, rco, reo);
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/cla_seq_adder.md
# cla_seq_adder

Multi-cycle WIDTH-bit adder controller that time-shares one 4-bit carry-lookahead slice. It accepts an operand pair over a valid/ready handshake and feeds the slice one nibble per cycle, LSB first, with the carry held in a register between nibbles. It returns the registered sum and carry-out over a second valid/ready handshake. It sits between an operand source (for example a register file or sequencer) and a result consumer, where a full-width CLA is too large.

## Interface
- WIDTH, 16, operand/sum width; must be a multiple of 4 and at least 4 (elaboration error otherwise)
- clk  input  1  single clock, rising-edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operand pair and cin are valid
- in_ready  output  1  block can accept operands (high only in IDLE)
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- cin  input  1  carry into nibble 0
- out_valid  output  1  sum/cout/ovf are valid
- out_ready  input  1  consumer takes the result
- sum  output  WIDTH  registered result
- cout  output  1  carry out of the MSB nibble
- ovf  output  1  signed overflow (see Configuration)
- busy  output  1  high in RUN or DONE

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE: in_ready=1. On in_valid&&in_ready:
  - latch a and b into operand registers
  - carry_q=cin
  - idx=0
  - clear sum
  - go to RUN
- RUN: each cycle the slice adds a[4*idx+:4], b[4*idx+:4] and carry_q.
  - Write the slice sum into sum[4*idx+:4].
  - Load the slice cout into carry_q.
  - idx increments.
  - When idx==WIDTH/4-1 is processed, go to DONE. At that point cout = final carry_q.
- DONE: out_valid=1. sum, cout and ovf are held stable until out_ready. On out_valid&&out_ready, go to IDLE.
- No new operands are accepted in RUN or DONE. a, b and cin are ignored outside the IDLE handshake.
- Arithmetic: modulo 2^WIDTH. cout is the true unsigned carry. Slice equations are standard:
  - p=a^b, g=a&b
  - c1..c3 and cout by full lookahead
  - s=p^{c3..c0}
- idx width is $clog2(WIDTH/4), with a minimum of 1 bit. idx never wraps inside RUN.

## Timing
- Reset (async assert, sync to clk on deassert):
  - state=IDLE, in_ready=1
  - out_valid=0, busy=0
  - sum=0, cout=0, ovf=0
  - carry_q=0, idx=0
- Latency: the accept edge is E0. The nibble k result is written at edge E(k+1). out_valid rises after edge E(WIDTH/4), i.e. 4 cycles for WIDTH=16 and 1 cycle for WIDTH=4.
- Throughput: one result per WIDTH/4+2 cycles with out_ready held high (accept, nibble edges, handoff).
- in_ready=0 from the cycle after acceptance until the cycle after the out handshake. There is no same-cycle out/in overlap.
- Backpressure: out_valid stays high indefinitely with outputs frozen while out_ready=0.
- Reset mid-RUN or mid-DONE: the partial result is discarded and all outputs take their reset values immediately.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Configuration
- CLA_SEQ_OVF_EN defined:
  - During the final nibble, register ovf = (carry into bit WIDTH-1) XOR (carry out of bit WIDTH-1).
  - Carry into bit WIDTH-1 is the slice's internal c3 on the last nibble.
  - ovf is valid with out_valid.
- CLA_SEQ_OVF_EN undefined: the ovf port still exists, is tied to 0, and has no ovf logic.

## Structure
- Package cla_seq_pkg:
  - state enum (IDLE, RUN, DONE)
  - localparam NIB=4
  - function for the idx width
- Sub-module cla4_slice: combinational inputs a[3:0], b[3:0], cin; outputs s[3:0], c3, cout. It holds the p/g lookahead logic.
- The controller holds the FSM, operand/sum registers, carry_q and idx.

## Test plan
- WIDTH=16, a=0x00FF, b=0x0001, cin=0 → sum=0x0100, cout=0, out_valid exactly 4 cycles after the accept edge.
- a=0xFFFF, b=0x0001, cin=0 → sum=0x0000, cout=1. a=0xFFFF, b=0x0000, cin=1 → sum=0x0000, cout=1.
- a=0x7FFF, b=0x0001 → sum=0x8000, cout=0, ovf=1 with CLA_SEQ_OVF_EN and ovf=0 without. a=0x8000, b=0x8000 → sum=0x0000, cout=1, ovf=1 (macro on).
- out_ready=0 for 10 cycles in DONE → out_valid, sum and cout stable and in_ready=0. in_valid pulses during RUN/DONE are ignored, with no second result.
- rst_n low during RUN cycle 2 → all outputs at reset values immediately. After release, a new add of 0x1234+0x4321 → sum=0x5555.
- WIDTH=4 instance: a=0xF, b=0x1 → sum=0x0, cout=1, out_valid 1 cycle after accept. 200 random back-to-back transactions match a golden model.
